// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle driving the ALU from latched
// operands, then a registered response held in RESP until accepted.
// Optional build macro ALU_ARB_OPCHK_EN: opcodes 100/110/111 are rejected
// with rsp_err=1 and bypass EXEC; otherwise rsp_err is always 0.
module alu_rr_arbiter #(
  parameter int BITS = 8,
  parameter int OPW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [BITS-1:0] req0_a,
  input  logic [BITS-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [BITS-1:0] req1_a,
  input  logic [BITS-1:0] req1_b,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [BITS-1:0] alu_r,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [BITS-1:0] rsp_data,
  output logic            rsp_zero,
  output logic            rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic            last_grant;
  logic            id_q;
  logic [OPW-1:0]  op_q;
  logic [BITS-1:0] a_q, b_q;

  logic            gnt0, gnt1, hs, hs_id, hs_illegal;
  logic [OPW-1:0]  hs_op;
  logic [BITS-1:0] hs_a, hs_b;

  // Grant: sole valid requester wins; on a tie, the one not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      gnt0 = req0_valid & (~req1_valid | last_grant);
      gnt1 = req1_valid & (~req0_valid | ~last_grant);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign hs         = gnt0 | gnt1;
  assign hs_id      = gnt1;
  assign hs_op      = gnt1 ? req1_op : req0_op;
  assign hs_a       = gnt1 ? req1_a  : req0_a;
  assign hs_b       = gnt1 ? req1_b  : req0_b;

`ifdef ALU_ARB_OPCHK_EN
  assign hs_illegal = (hs_op == OPW'(3'b100)) || (hs_op == OPW'(3'b110)) ||
                      (hs_op == OPW'(3'b111));
`else
  assign hs_illegal = 1'b0;
`endif

  // ALU always sees the latched operands, so it never floats or glitches.
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

  // Issue FSM: latch on handshake, capture ALU result, hold until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            last_grant <= hs_id;
            if (hs_illegal) begin
              // Rejected op: answer immediately, leave the ALU drive alone.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= hs_id;
              rsp_data  <= '0;
              rsp_zero  <= 1'b0;
              rsp_err   <= 1'b1;
            end else begin
              state <= EXEC;
              id_q  <= hs_id;
              op_q  <= hs_op;
              a_q   <= hs_a;
              b_q   <= hs_b;
            end
          end
        end
        EXEC: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_data  <= alu_r;
          rsp_zero  <= alu_zero;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter; the bench supplies the ALU itself.
module tb_alu_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0] alu_a, alu_b, alu_r;
  logic [2:0] alu_op;
  logic       alu_zero;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [7:0] rsp_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.BITS(8), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Reference ALU; undefined opcodes return a^b so pass-through is visible.
  always_comb begin
    case (alu_op)
      3'b000:  alu_r = alu_a + alu_b;
      3'b001:  alu_r = alu_a - alu_b;
      3'b010:  alu_r = alu_a & alu_b;
      3'b011:  alu_r = alu_a | alu_b;
      3'b101:  alu_r = {7'd0, alu_a < alu_b};
      default: alu_r = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_r == 8'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single requester op with rsp_ready=1: grant in N, EXEC in N+1, response in N+2.
  task automatic one_op(input logic id, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ed, input logic ez,
                        input string tag);
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    rsp_ready = 1;
    #1;
    chk({tag, "_rdy0"}, req0_ready, !id);
    chk({tag, "_rdy1"}, req1_ready, id);
    tick();
    req0_valid = 0; req1_valid = 0;
    #1;
    chk({tag, "_exec_vld"}, rsp_valid, 0);
    chk({tag, "_alu_op"}, alu_op, op);
    chk({tag, "_alu_a"}, alu_a, a);
    tick();
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_data"}, rsp_data, ed);
    chk({tag, "_zero"}, rsp_zero, ez);
    chk({tag, "_err"}, rsp_err, 0);
    tick();
    chk({tag, "_drop"}, rsp_valid, 0);
  endtask

  initial begin
    rst = 1; rsp_ready = 0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    tick();
    // No ready while reset is held, even with a valid request.
    req0_valid = 1; #1;
    chk("rst_rdy0", req0_ready, 0);
    req0_valid = 0;
    tick();
    rst = 0; #1;
    chk("rst_vld", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    tick();

    // req0 ADD 0x7F+0x01
    one_op(0, 3'b000, 8'h7F, 8'h01, 8'h80, 0, "add");

    // Fresh reset so the first tie goes to req0, then alternate 0,1,0,1.
    rst = 1; tick(); rst = 0;
    req0_valid = 1; req0_op = 3'b001; req0_a = 8'h05; req0_b = 8'h05;
    req1_valid = 1; req1_op = 3'b011; req1_a = 8'hF0; req1_b = 8'h0F;
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_rdy0", k), req0_ready, (k % 2) == 0);
      chk($sformatf("rr%0d_rdy1", k), req1_ready, (k % 2) == 1);
      tick();
      chk($sformatf("rr%0d_exec_rdy", k), {req0_ready, req1_ready}, 0);
      tick();
      chk($sformatf("rr%0d_vld", k), rsp_valid, 1);
      chk($sformatf("rr%0d_id", k), rsp_id, k % 2);
      chk($sformatf("rr%0d_data", k), rsp_data, (k % 2) ? 8'hFF : 8'h00);
      chk($sformatf("rr%0d_zero", k), rsp_zero, (k % 2) ? 0 : 1);
      chk($sformatf("rr%0d_resp_rdy", k), {req0_ready, req1_ready}, 0);
      tick();
    end
    req0_valid = 0; req1_valid = 0;

    // Backpressure on req1 AND 0xAA&0x55; req0 waits with ADD 0xFF+0x02.
    rsp_ready = 0;
    req1_valid = 1; req1_op = 3'b010; req1_a = 8'hAA; req1_b = 8'h55;
    #1;
    chk("bp_rdy1", req1_ready, 1);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_op = 3'b000; req0_a = 8'hFF; req0_b = 8'h02;
    #1;
    chk("bp_exec_rdy0", req0_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_vld", i), rsp_valid, 1);
      chk($sformatf("bp%0d_id", i), rsp_id, 1);
      chk($sformatf("bp%0d_data", i), rsp_data, 8'h00);
      chk($sformatf("bp%0d_zero", i), rsp_zero, 1);
      chk($sformatf("bp%0d_rdy", i), {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1; #1;
    chk("bp_rel_vld", rsp_valid, 1);
    tick();
    chk("bp_after_vld", rsp_valid, 0);
    chk("wrap_rdy0", req0_ready, 1);
    tick();
    req0_valid = 0;
    tick();
    chk("wrap_vld", rsp_valid, 1);
    chk("wrap_id", rsp_id, 0);
    chk("wrap_data", rsp_data, 8'h01);
    chk("wrap_zero", rsp_zero, 0);
    tick();

    // Compare: 3<9 -> 1, 9<3 -> 0 with zero flag.
    one_op(1, 3'b101, 8'd3, 8'd9, 8'h01, 0, "slt_lt");
    one_op(0, 3'b101, 8'd9, 8'd3, 8'h00, 1, "slt_ge");

    // Reset while in EXEC.
    req0_valid = 1; req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h01;
    #1;
    chk("rx_rdy0", req0_ready, 1);
    tick();
    rst = 1; req1_valid = 1;
    #1;
    chk("rx_exec_rdy", {req0_ready, req1_ready}, 0);
    tick();
    rst = 0; #1;
    chk("rx_vld", rsp_valid, 0);
    chk("rx_data", rsp_data, 0);
    chk("rx_alu_a", alu_a, 0);
    chk("rx_alu_op", alu_op, 0);
    chk("rx_tie_rdy0", req0_ready, 1);
    chk("rx_tie_rdy1", req1_ready, 0);
    rsp_ready = 0;
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("rr_resp_vld", rsp_valid, 1);
    chk("rr_resp_data", rsp_data, 8'h02);
    // Reset while in RESP with an unaccepted response.
    rst = 1;
    tick();
    rst = 0;
    req0_valid = 1; req0_op = 3'b011; req0_a = 8'h30; req0_b = 8'h03;
    req1_valid = 1;
    rsp_ready = 1;
    #1;
    chk("rr_vld", rsp_valid, 0);
    chk("rr_data", rsp_data, 0);
    chk("rr_id", rsp_id, 0);
    chk("rr_zero", rsp_zero, 0);
    chk("rr_alu_a", alu_a, 0);
    chk("rr_tie_rdy0", req0_ready, 1);
    chk("rr_tie_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("or_alu_op", alu_op, 3'b011);
    chk("or_alu_a", alu_a, 8'h30);
    tick();
    chk("or_vld", rsp_valid, 1);
    chk("or_data", rsp_data, 8'h33);
    tick();

    // Opcode 110: rejected early with the check enabled, passed through otherwise.
    req0_valid = 1; req0_op = 3'b110; req0_a = 8'h01; req0_b = 8'h02;
    #1;
    chk("ill_rdy0", req0_ready, 1);
    tick();
    req0_valid = 0;
`ifdef ALU_ARB_OPCHK_EN
    #1;
    chk("ill_vld", rsp_valid, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_data", rsp_data, 0);
    chk("ill_zero", rsp_zero, 0);
    chk("ill_alu_op", alu_op, 3'b011);
    chk("ill_alu_a", alu_a, 8'h30);
    tick();
    chk("ill_drop", rsp_valid, 0);
`else
    #1;
    chk("ill_exec_vld", rsp_valid, 0);
    chk("ill_alu_op", alu_op, 3'b110);
    tick();
    chk("ill_vld", rsp_valid, 1);
    chk("ill_err", rsp_err, 0);
    chk("ill_data", rsp_data, 8'h03);
    chk("ill_zero", rsp_zero, 0);
    tick();
    chk("ill_drop", rsp_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one combinational 8-bit ALU between two requesters, such as the fetch/PC-update path and the execute path.
- Each requester issues an operation with a valid/ready handshake.
- The arbiter grants requesters round-robin and latches the operands.
- It drives the ALU for one cycle, registers the result and zero flag, and returns them on a shared response channel tagged with the requester ID.

Parameters:
- BITS, 8, datapath width of operands and result.
- OPW, 3, opcode width (000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT/JUMP compare).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  OPW  requester 0 opcode.
- req0_a  in  BITS  requester 0 operand A.
- req0_b  in  BITS  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- alu_a  out  BITS  operand A to ALU.
- alu_b  out  BITS  operand B to ALU.
- alu_op  out  OPW  opcode to ALU.
- alu_r  in  BITS  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  BITS  registered result.
- rsp_zero  out  1  registered zero flag.
- rsp_err  out  1  illegal opcode flag; always 0 unless ALU_ARB_OPCHK_EN is defined.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0, latched op/a/b=0, last_grant=1 (so requester 0 wins the first tie).
- IDLE:
  - req0_ready/req1_ready are combinational: grant = valid requester; on tie, the one not equal to last_grant. At most one ready is high per cycle.
  - On a handshake (valid & ready): latch op/a/b and id, set last_grant=id, go to EXEC.
  - With no valid requester, stay in IDLE.
- EXEC (exactly one cycle):
  - alu_a/alu_b/alu_op are driven from the latched registers.
  - At the clock edge, capture alu_r into rsp_data and alu_zero into rsp_zero, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/data/zero/err hold stable until rsp_ready.
  - When rsp_ready=1: clear rsp_valid, go to IDLE. The new grant occurs no earlier than the following cycle, giving a 3-cycle minimum issue interval.
- Both ready outputs are 0 in EXEC and RESP. A requester holding valid waits; its op/a/b may change until its handshake.
- Latency: handshake in cycle N, response visible in cycle N+2.
- ALU drive outside EXEC: alu_a, alu_b and alu_op hold the latched values, so there is no Z/glitch fan-out from undefined opcodes at reset, and all are 0 after reset.
- Arithmetic is entirely in the ALU; the arbiter does no width extension. rsp_data is BITS wide and wraps modulo 2^BITS per the ALU.
- Fairness: with both valid continuously, grants alternate 0,1,0,1. With only one valid, it is granted every issue slot regardless of last_grant.
- rst asserted in any state: next cycle is IDLE with reset values. An in-flight or unaccepted response is discarded. No ready is asserted during the reset cycle.
- rsp_ready in IDLE/EXEC is ignored.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- Defined:
  - Opcodes 100, 110 and 111 are illegal. On a handshake with an illegal opcode, skip EXEC and go IDLE→RESP directly, 1 cycle faster.
  - The response is rsp_err=1, rsp_data=0, rsp_zero=0. alu_op/a/b are not updated (the ALU is not driven with the illegal code).
  - Legal opcodes return rsp_err=0.
- Undefined: rsp_err is tied 0; every opcode goes through EXEC and the ALU output is captured as-is.

Test Plan:
- Reset, then req0 only: op=000, a=0x7F, b=0x01, rsp_ready=1 -> req0_ready in cycle N, rsp_valid in N+2 with rsp_id=0, rsp_data=0x80, rsp_zero=0.
- Both valid continuously, req0 SUB 5-5, req1 OR 0xF0|0x0F, rsp_ready=1 -> grant order 0,1,0,1; responses (id0, 0x00, zero=1), (id1, 0xFF, zero=0); never both ready high.
- Backpressure: rsp_ready=0 for 5 cycles after req1 AND 0xAA&0x55 -> rsp_valid stays 1 with rsp_data=0x00, rsp_zero=1, both ready=0; release -> rsp_valid drops next cycle.
- Wrap and compare: ADD 0xFF+0x02 -> rsp_data=0x01; opcode 101 with a=3, b=9 -> rsp_data=0x01; with a=9, b=3 -> rsp_data=0x00, rsp_zero=1.
- rst pulsed in EXEC and in RESP -> next cycle rsp_valid=0, all outputs 0, and the first post-reset tie is granted to req0.
- With ALU_ARB_OPCHK_EN: req0 op=110 -> rsp_valid in N+1 with rsp_err=1, rsp_data=0, alu_op unchanged. Without the macro: the same stimulus gives a response in N+2 with rsp_err=0.
